// File: rtl/coupling_axi_ctrl.sv
// AXI4-Lite slave for the NxN coupled-cell array: decodes host writes into a
// one-cycle broadcast commit, muxes cell readback, and owns the ising_rstn control bit.
module coupling_axi_ctrl #(
  parameter int N      = 8,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
) (
  input  logic                     clk,
  input  logic                     axi_rstn,
  input  logic                     s_awvalid,
  output logic                     s_awready,
  input  logic [ADDR_W-1:0]        s_awaddr,
  input  logic                     s_wvalid,
  output logic                     s_wready,
  input  logic [DATA_W-1:0]        s_wdata,
  output logic                     s_bvalid,
  input  logic                     s_bready,
  output logic [1:0]               s_bresp,
  input  logic                     s_arvalid,
  output logic                     s_arready,
  input  logic [ADDR_W-1:0]        s_araddr,
  output logic                     s_rvalid,
  input  logic                     s_rready,
  output logic [DATA_W-1:0]        s_rdata,
  output logic [1:0]               s_rresp,
  output logic                     wready,
  output logic [N*N-1:0]           wr_addr_match,
  output logic [DATA_W-1:0]        wdata,
  input  logic [DATA_W*N*N-1:0]    cell_rdata,
  output logic                     ising_rstn
);

  localparam int CELLS  = N * N;
  localparam int IDX_W  = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam int WORD_W = ADDR_W - 2;
  localparam logic [WORD_W-1:0] CELL_BASE = WORD_W'(32'h400);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t w_state;
  r_state_t r_state;

  logic              aw_held, w_held;
  logic [WORD_W-1:0] awaddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              aw_hs, w_hs, ar_hs;
  logic [WORD_W-1:0] cur_aword, ar_word;
  logic [DATA_W-1:0] cur_wdata, rd_sel;
  logic              unused_addr_lsbs;

  function automatic logic is_ctrl(input logic [WORD_W-1:0] w);
    return w == '0;
  endfunction

  // Full compare against CELLS so indices past the array never alias into it.
  function automatic logic is_cell(input logic [WORD_W-1:0] w);
    return (w >= CELL_BASE) && ((w - CELL_BASE) < WORD_W'(CELLS));
  endfunction

  function automatic logic [IDX_W-1:0] cell_idx(input logic [WORD_W-1:0] w);
    return IDX_W'(w - CELL_BASE);
  endfunction

  assign unused_addr_lsbs = ^{s_awaddr[1:0], s_araddr[1:0]};

  always_comb begin
    aw_hs     = s_awvalid && s_awready;
    w_hs      = s_wvalid && s_wready;
    ar_hs     = s_arvalid && s_arready;
    cur_aword = aw_held ? awaddr_q : s_awaddr[ADDR_W-1:2];
    cur_wdata = w_held ? wdata_q : s_wdata;
    ar_word   = s_araddr[ADDR_W-1:2];
    rd_sel    = '0;
    if (is_cell(ar_word))
      rd_sel = cell_rdata[int'(cell_idx(ar_word))*DATA_W +: DATA_W];
    else if (is_ctrl(ar_word))
      rd_sel = {{(DATA_W-1){1'b0}}, ising_rstn};
  end

  always_ff @(posedge clk) begin
    if (w_state == W_IDLE && aw_hs) awaddr_q <= s_awaddr[ADDR_W-1:2];
    if (w_state == W_IDLE && w_hs)  wdata_q  <= s_wdata;
  end

  // Write path: capture AW/W in any order, one commit cycle, then response.
  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      w_state       <= W_IDLE;
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      s_awready     <= 1'b0;
      s_wready      <= 1'b0;
      s_bvalid      <= 1'b0;
      s_bresp       <= RESP_OKAY;
      wready        <= 1'b0;
      wr_addr_match <= '0;
      wdata         <= '0;
      ising_rstn    <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_hs) aw_held <= 1'b1;
          if (w_hs)  w_held  <= 1'b1;
          if ((aw_held || aw_hs) && (w_held || w_hs)) begin
            w_state   <= W_COMMIT;
            s_awready <= 1'b0;
            s_wready  <= 1'b0;
            if (is_cell(cur_aword)) begin
              wready        <= 1'b1;
              wr_addr_match <= CELLS'(1) << cell_idx(cur_aword);
              wdata         <= cur_wdata;
            end
          end else begin
            s_awready <= !(aw_held || aw_hs);
            s_wready  <= !(w_held || w_hs);
          end
        end
        W_COMMIT: begin
          wready        <= 1'b0;
          wr_addr_match <= '0;
          if (is_ctrl(awaddr_q)) ising_rstn <= wdata_q[0];
          s_bvalid <= 1'b1;
          s_bresp  <= (is_ctrl(awaddr_q) || is_cell(awaddr_q)) ? RESP_OKAY : RESP_SLVERR;
          w_state  <= W_RESP;
        end
        W_RESP: begin
          if (s_bready) begin
            s_bvalid  <= 1'b0;
            s_bresp   <= RESP_OKAY;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            s_awready <= 1'b1;
            s_wready  <= 1'b1;
            w_state   <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read path: data sampled on the AR handshake edge and held until rready.
  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      r_state   <= R_IDLE;
      s_arready <= 1'b0;
      s_rvalid  <= 1'b0;
      s_rdata   <= '0;
      s_rresp   <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            r_state   <= R_DATA;
            s_arready <= 1'b0;
            s_rvalid  <= 1'b1;
            s_rdata   <= rd_sel;
            s_rresp   <= (is_ctrl(ar_word) || is_cell(ar_word)) ? RESP_OKAY : RESP_SLVERR;
          end else begin
            s_arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (s_rready) begin
            r_state   <= R_IDLE;
            s_rvalid  <= 1'b0;
            s_rdata   <= '0;
            s_rresp   <= RESP_OKAY;
            s_arready <= 1'b1;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule
